fpu_add_pipe_ctrl: RTL and testbench

//  Valid/ready sequencer for the multi-stage FP add/sub datapath: exponent align,
//  add, normalise, exponent update, round. Tracks one valid bit and one tag per stage
//  and drives the per-stage register enables of the datapath pipeline registers.

---
 rtl/fpu_add_pipe_ctrl_if.sv | 22 ++
 rtl/fpu_add_pipe_ctrl.sv | 95 +++++++++
 tb/tb_fpu_add_pipe_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fpu_add_pipe_ctrl_if.sv
// Issue/result handshake bundle for the FP add/sub pipeline controller.
// The master drives operations in and takes results out. The slave is the controller.
interface fpu_add_pipe_ctrl_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_tag, out_ready,
        input  in_ready, out_valid, out_tag
    );

    modport slave (
        input  in_valid, in_tag, out_ready,
        output in_ready, out_valid, out_tag
    );
endinterface

// File: rtl/fpu_add_pipe_ctrl.sv
// Valid/ready sequencer for the FP add/sub datapath. It collapses bubbles and applies back-pressure.
// Optional sticky {ovf,unf} exception flags are enabled by defining FPU_EXC_STICKY_EN.
module fpu_add_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int TAG_W  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    fpu_add_pipe_ctrl_if.slave           bus,
    input  logic                         flush,
    output logic [STAGES-1:0]            stage_en,
    input  logic                         ovf_in,
    input  logic                         unf_in,
    input  logic                         exc_clr,
    output logic [1:0]                   exc_sticky,
    output logic                         busy,
    output logic [$clog2(STAGES+1)-1:0]  inflight
);
    localparam int CNT_W = $clog2(STAGES + 1);

    logic [STAGES-1:0] v_q;
    logic [TAG_W-1:0]  tag_q [STAGES];
    logic [STAGES-1:0] rdy;
    logic [CNT_W-1:0]  cnt;

    // An empty stage always accepts, so a bubble is absorbed even while the output is stalled.
    always_comb begin
        rdy = '0;
        rdy[STAGES-1] = !v_q[STAGES-1] | bus.out_ready;
        for (int i = STAGES - 2; i >= 0; i--) begin
            rdy[i] = !v_q[i] | rdy[i+1];
        end
    end

    assign bus.in_ready  = rdy[0] & !flush;
    assign stage_en      = rdy;
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.out_tag   = tag_q[STAGES-1];

    // A flush drops every valid bit but leaves the tags untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                tag_q[i] <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            if (rdy[0]) begin
                v_q[0]   <= bus.in_valid & bus.in_ready;
                tag_q[0] <= bus.in_tag;
            end
            for (int i = 1; i < STAGES; i++) begin
                if (rdy[i]) begin
                    v_q[i]   <= v_q[i-1];
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

    always_comb begin
        cnt = '0;
        for (int i = 0; i < STAGES; i++) begin
            cnt = cnt + CNT_W'(v_q[i]);
        end
    end

    assign inflight = cnt;
    assign busy     = |v_q;

`ifdef FPU_EXC_STICKY_EN
    logic [1:0] sticky_q;
    logic       fire;

    assign fire = v_q[STAGES-1] & bus.out_ready;

    // If a set and a clear happen together, the set wins. This keeps the new event visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q[1] <= (sticky_q[1] & !exc_clr) | (fire & ovf_in);
            sticky_q[0] <= (sticky_q[0] & !exc_clr) | (fire & unf_in);
        end
    end

    assign exc_sticky = sticky_q;
`else
    logic unused_exc;
    assign unused_exc = ^{ovf_in, unf_in, exc_clr};
    assign exc_sticky = 2'b00;
`endif
endmodule

// File: tb/tb_fpu_add_pipe_ctrl.sv
// Directed, table-driven bench for fpu_add_pipe_ctrl (STAGES=4, TAG_W=4).
// Hand-written sequences cover the asynchronous reset and the sticky flags.
module tb_fpu_add_pipe_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic [3:0] stage_en;
    logic       ovf_in;
    logic       unf_in;
    logic       exc_clr;
    logic [1:0] exc_sticky;
    logic       busy;
    logic [2:0] inflight;

    int n_compared   = 0;
    int n_mismatched = 0;

    fpu_add_pipe_ctrl_if #(.TAG_W(4)) bus ();

    fpu_add_pipe_ctrl #(.STAGES(4), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .flush      (flush),
        .stage_en   (stage_en),
        .ovf_in     (ovf_in),
        .unf_in     (unf_in),
        .exc_clr    (exc_clr),
        .exc_sticky (exc_sticky),
        .busy       (busy),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [3:0] itag;
        logic       ordy;
        logic       fl;
        logic       ov;
        logic [3:0] otag;
        logic       irdy;
        logic [3:0] sen;
        logic [2:0] inf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic iv, logic [3:0] itag, logic ordy, logic fl,
                                logic ov, logic [3:0] otag, logic irdy,
                                logic [3:0] sen, logic [2:0] inf);
        vec_t r;
        r.iv = iv; r.itag = itag; r.ordy = ordy; r.fl = fl;
        r.ov = ov; r.otag = otag; r.irdy = irdy; r.sen = sen; r.inf = inf;
        return r;
    endfunction

    task automatic applyStimulus(input logic iv, input logic [3:0] itag,
                                 input logic ordy, input logic fl);
        bus.in_valid  = iv;
        bus.in_tag    = itag;
        bus.out_ready = ordy;
        flush         = fl;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        n_compared++;
        if (act != exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] exp_ovf;
        logic [1:0] exp_clr;
`ifdef FPU_EXC_STICKY_EN
        exp_ovf = 2'b10;
        exp_clr = 2'b01;
`else
        exp_ovf = 2'b00;
        exp_clr = 2'b00;
`endif

        // Back-to-back tags 1,2,3 with the consumer always ready.
        vecs.push_back(mk(1, 1, 1, 0,  0, 0, 1, 4'b1111, 0));
        vecs.push_back(mk(1, 2, 1, 0,  0, 0, 1, 4'b1111, 1));
        vecs.push_back(mk(1, 3, 1, 0,  0, 0, 1, 4'b1111, 2));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 4'b1111, 3));
        vecs.push_back(mk(0, 0, 1, 0,  1, 1, 1, 4'b1111, 3));
        vecs.push_back(mk(0, 0, 1, 0,  1, 2, 1, 4'b1111, 2));
        vecs.push_back(mk(0, 0, 1, 0,  1, 3, 1, 4'b1111, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 4'b1111, 0));
        // Fill all four stages while stalled, then drain.
        vecs.push_back(mk(1, 1, 0, 0,  0, 0, 1, 4'b1111, 0));
        vecs.push_back(mk(1, 2, 0, 0,  0, 0, 1, 4'b1111, 1));
        vecs.push_back(mk(1, 3, 0, 0,  0, 0, 1, 4'b1111, 2));
        vecs.push_back(mk(1, 4, 0, 0,  0, 0, 1, 4'b1111, 3));
        vecs.push_back(mk(1, 5, 0, 0,  1, 1, 0, 4'b0000, 4));
        vecs.push_back(mk(1, 5, 0, 0,  1, 1, 0, 4'b0000, 4));
        vecs.push_back(mk(0, 0, 1, 0,  1, 1, 1, 4'b1111, 4));
        vecs.push_back(mk(0, 0, 1, 0,  1, 2, 1, 4'b1111, 3));
        vecs.push_back(mk(0, 0, 1, 0,  1, 3, 1, 4'b1111, 2));
        vecs.push_back(mk(0, 0, 1, 0,  1, 4, 1, 4'b1111, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 4'b1111, 0));
        // Bubble collapse: tag 5, two idle cycles, tag 6, consumer stalled.
        vecs.push_back(mk(1, 5, 0, 0,  0, 0, 1, 4'b1111, 0));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 4'b1111, 1));
        vecs.push_back(mk(0, 0, 0, 0,  0, 0, 1, 4'b1111, 1));
        vecs.push_back(mk(1, 6, 0, 0,  0, 0, 1, 4'b1111, 1));
        vecs.push_back(mk(0, 0, 0, 0,  1, 5, 1, 4'b0111, 2));
        vecs.push_back(mk(0, 0, 0, 0,  1, 5, 1, 4'b0111, 2));
        vecs.push_back(mk(0, 0, 0, 0,  1, 5, 1, 4'b0011, 2));
        vecs.push_back(mk(0, 0, 0, 0,  1, 5, 1, 4'b0011, 2));
        vecs.push_back(mk(0, 0, 1, 0,  1, 5, 1, 4'b1111, 2));
        vecs.push_back(mk(0, 0, 1, 0,  1, 6, 1, 4'b1111, 1));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 4'b1111, 0));
        // Flush with three in flight while a result is being delivered.
        vecs.push_back(mk(1, 7, 1, 0,  0, 0, 1, 4'b1111, 0));
        vecs.push_back(mk(1, 8, 1, 0,  0, 0, 1, 4'b1111, 1));
        vecs.push_back(mk(1, 9, 1, 0,  0, 0, 1, 4'b1111, 2));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 4'b1111, 3));
        vecs.push_back(mk(1, 10, 1, 1, 1, 7, 0, 4'b1111, 3));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 4'b1111, 0));
        vecs.push_back(mk(0, 0, 1, 0,  0, 0, 1, 4'b1111, 0));

        rst     = 1'b1;
        ovf_in  = 1'b0;
        unf_in  = 1'b0;
        exc_clr = 1'b0;
        applyStimulus(0, 0, 0, 0);
        #1;
        checkOutput("reset out_valid", int'(bus.out_valid), 0);
        checkOutput("reset out_tag", int'(bus.out_tag), 0);
        checkOutput("reset in_ready", int'(bus.in_ready), 1);
        checkOutput("reset stage_en", int'(stage_en), 4'b1111);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset inflight", int'(inflight), 0);
        checkOutput("reset exc_sticky", int'(exc_sticky), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (vecs[k]) begin
            applyStimulus(vecs[k].iv, vecs[k].itag, vecs[k].ordy, vecs[k].fl);
            #1;
            checkOutput($sformatf("vec%0d out_valid", k), int'(bus.out_valid), int'(vecs[k].ov));
            if (vecs[k].ov)
                checkOutput($sformatf("vec%0d out_tag", k), int'(bus.out_tag), int'(vecs[k].otag));
            checkOutput($sformatf("vec%0d in_ready", k), int'(bus.in_ready), int'(vecs[k].irdy));
            checkOutput($sformatf("vec%0d stage_en", k), int'(stage_en), int'(vecs[k].sen));
            checkOutput($sformatf("vec%0d inflight", k), int'(inflight), int'(vecs[k].inf));
            checkOutput($sformatf("vec%0d busy", k), int'(busy), int'(vecs[k].inf != 0));
            step();
        end

        // Reset asserted mid-stream with four in flight.
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1, 4'(i), 0, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0);
        #1;
        checkOutput("prereset inflight", int'(inflight), 4);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst out_valid", int'(bus.out_valid), 0);
        checkOutput("midrst inflight", int'(inflight), 0);
        checkOutput("midrst busy", int'(busy), 0);
        step();
        rst = 1'b0;
        applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            #1;
            checkOutput($sformatf("postrst%0d out_valid", i), int'(bus.out_valid), 0);
            step();
        end

        // Sticky exception flags.
        ovf_in = 1'b1;
        unf_in = 1'b1;
        step();
        ovf_in = 1'b0;
        unf_in = 1'b0;
        checkOutput("sticky idle flags", int'(exc_sticky), 0);
        applyStimulus(1, 1, 1, 0);
        step();
        applyStimulus(1, 2, 1, 0);
        step();
        applyStimulus(0, 0, 1, 0);
        step();
        step();
        ovf_in = 1'b1;
        #1;
        checkOutput("sticky op1 out_tag", int'(bus.out_tag), 1);
        step();
        ovf_in = 1'b0;
        checkOutput("sticky ovf set", int'(exc_sticky), int'(exp_ovf));
        checkOutput("sticky op2 out_tag", int'(bus.out_tag), 2);
        unf_in  = 1'b1;
        exc_clr = 1'b1;
        step();
        unf_in = 1'b0;
        checkOutput("sticky clr+unf", int'(exc_sticky), int'(exp_clr));
        step();
        exc_clr = 1'b0;
        checkOutput("sticky clr only", int'(exc_sticky), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
